// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Values at or beyond the modulus are pinned to the top count.
  function automatic logic [31:0] clamp_mod(input logic [31:0] val,
                                            input logic [31:0] modulus);
    return (val >= modulus) ? (modulus - 32'd1) : val;
  endfunction

endpackage

// File: rtl/mod_next_val.sv
// Next-state logic for mod_updown_counter: load clamp, step, wrap/saturate.
// COUNTER_SAT_EN selects saturation at the ends instead of modulo wrap.
module mod_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_evt
);

  // Compares are done at 32 bits so MODULUS == 2**WIDTH needs no special case.
  localparam logic [31:0] LAST = 32'(MODULUS - 1);

  logic [31:0] q_ext;
  logic        at_last, at_zero, in_range;

  assign q_ext    = 32'(q);
  assign at_last  = (q_ext == LAST);
  assign at_zero  = (q == '0);
  assign in_range = (q_ext <= LAST);

  always_comb begin
    next_q   = q;
    wrap_evt = 1'b0;
    if (load) begin
      next_q = WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));
    end else if (en) begin
      if (!in_range) begin
        next_q = '0;
      end else if (up_dn == DIR_UP) begin
        if (at_last) begin
          wrap_evt = 1'b1;
`ifdef COUNTER_SAT_EN
          next_q   = q;
`else
          next_q   = '0;
`endif
        end else begin
          next_q = q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          wrap_evt = 1'b1;
`ifdef COUNTER_SAT_EN
          next_q   = q;
`else
          next_q   = WIDTH'(LAST);
`endif
        end else begin
          next_q = q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load, enable, terminal count and wrap pulse.
// Define COUNTER_SAT_EN to saturate at 0 / MODULUS-1 instead of wrapping.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [31:0] LAST = 32'(MODULUS - 1);

  if (WIDTH < 1 || WIDTH > 30) begin : g_bad_width
    $error("mod_updown_counter: WIDTH %0d out of range", WIDTH);
  end
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
    $error("mod_updown_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_rst
    $error("mod_updown_counter: RESET_VAL %0d not below MODULUS", RESET_VAL);
  end

  logic [WIDTH-1:0] next_q;
  logic             wrap_evt;

  mod_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q        (q),
    .up_dn    (up_dn),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .next_q   (next_q),
    .wrap_evt (wrap_evt)
  );

  // Early warning: high in the cycle whose edge will wrap or saturate.
  assign tc = en & ~load & ((up_dn == DIR_UP) ? (32'(q) == LAST) : (q == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= WIDTH'(RESET_VAL);
      wrap <= 1'b0;
    end else begin
      q    <= next_q;
      wrap <= wrap_evt;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (WIDTH=4, MODULUS=10, RESET_VAL=0).
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, up_dn = 1'b1, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] q;
  logic       tc, wrap;

  typedef struct {
    string      nm;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
    end
  endtask

  // Monitor: values are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "q",    int'(q),    int'(e.q));
      chk(e.nm, "tc",   int'(tc),   int'(e.tc));
      chk(e.nm, "wrap", int'(wrap), int'(e.wrap));
    end
  end

  // One cycle: inputs applied just after posedge; expected q/wrap are the
  // values registered on that posedge (or forced by rst), tc follows inputs.
  task automatic cyc(input string nm, input logic r, input logic e, input logic u,
                     input logic l, input logic [3:0] lv,
                     input logic [3:0] eq, input logic etc, input logic ew);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; up_dn = u; load = l; load_val = lv;
    x.nm = nm; x.q = eq; x.tc = etc; x.wrap = ew;
    sb.push_back(x);
  endtask

  initial begin
    logic [3:0] upq [12];
    logic [3:0] dnq [5];
    upq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
    dnq = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};

    // reset held with en=1
    cyc("rst0", 1, 1, 1, 0, 0, 0, 0, 0);
    cyc("rst1", 1, 1, 1, 0, 0, 0, 0, 0);

`ifdef COUNTER_SAT_EN
    cyc("sat_ld8", 0, 0, 1, 1, 8, 0, 0, 0);
    cyc("sat_u0",  0, 1, 1, 0, 0, 8, 0, 0);
    cyc("sat_u1",  0, 1, 1, 0, 0, 9, 1, 0);
    cyc("sat_u2",  0, 1, 1, 0, 0, 9, 1, 1);
    cyc("sat_ld1", 0, 1, 1, 1, 1, 9, 0, 1);
    cyc("sat_d0",  0, 1, 0, 0, 0, 1, 0, 0);
    cyc("sat_d1",  0, 1, 0, 0, 0, 0, 1, 0);
    cyc("sat_ld7", 0, 0, 0, 1, 7, 0, 0, 1);
`else
    for (int i = 0; i < 12; i++)
      cyc($sformatf("up%0d", i), 0, 1, 1, 0, 0, upq[i], upq[i] == 4'd9, i == 10);
    for (int i = 0; i < 5; i++)
      cyc($sformatf("dn%0d", i), 0, 1, 0, 0, 0, dnq[i], dnq[i] == 4'd0, i == 3);
`endif

    // load priority and clamping; tc masked while loading
    cyc("ld9",    0, 1, 1, 1, 9,  7, 0, 0);
    cyc("ld7tc",  0, 1, 1, 1, 7,  9, 0, 0);
    cyc("ld13",   0, 1, 0, 1, 13, 7, 0, 0);
    cyc("ld4",    0, 1, 1, 1, 4,  9, 0, 0);
    // enable gating and direction flip
    cyc("en1a",   0, 1, 1, 0, 0, 4, 0, 0);
    cyc("en0a",   0, 0, 1, 0, 0, 5, 0, 0);
    cyc("en1b",   0, 1, 1, 0, 0, 5, 0, 0);
    cyc("en0b",   0, 0, 1, 0, 0, 6, 0, 0);
    cyc("flip",   0, 1, 0, 0, 0, 6, 0, 0);
    cyc("flip_q", 0, 0, 0, 0, 0, 5, 0, 0);
    // async reset mid-count at 6: q clears before the next edge
    cyc("ld6",    0, 0, 1, 1, 6, 5, 0, 0);
    cyc("at6",    0, 1, 1, 0, 0, 6, 0, 0);
    cyc("arst",   1, 1, 1, 0, 0, 0, 0, 0);
    cyc("arel",   0, 1, 1, 0, 0, 0, 0, 0);
    // async reset also clears a pending wrap pulse
    cyc("ld9b",   0, 0, 1, 1, 9, 1, 0, 0);
    cyc("wrapup", 0, 1, 1, 0, 0, 9, 1, 0);
    cyc("wrst",   1, 1, 1, 0, 0, 0, 0, 0);
    cyc("wrel",   0, 0, 1, 0, 0, 0, 0, 0);
    cyc("end",    0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
